frame_scheduler: RTL

//  Sequences overlapped analysis frames for the MFCC front end. Buffers pre-emphasised samples in a

---
 rtl/frame_scheduler_pkg.sv | 32 +++
 rtl/frame_ring_ram.sv | 24 ++
 rtl/frame_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared widths, FSM encoding and output beat payload for the MFCC frame scheduler.
package frame_scheduler_pkg;

  localparam int unsigned DW        = 16;
  localparam int unsigned AW        = 9;
  localparam int unsigned DEPTH     = 1 << AW;
  localparam int unsigned MAX_FRAME = 256;
  localparam int unsigned CFG_W     = 9;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned CNT_W     = AW + 1;
  localparam int unsigned FC_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  typedef struct packed {
    logic [DW-1:0]    sample;
    logic [IDX_W-1:0] index;
    logic             first;
    logic             last;
  } beat_t;

  // Legal frame config: 1 <= fl <= MAX_FRAME, 1 <= hl <= fl.
  function automatic logic cfg_legal(input logic [CFG_W-1:0] fl, input logic [CFG_W-1:0] hl);
    return (fl != '0) && (fl <= CFG_W'(MAX_FRAME)) && (hl != '0) && (hl <= fl);
  endfunction

endpackage

// File: rtl/frame_ring_ram.sv
// Sample ring storage: one synchronous write port, one asynchronous read port, no array reset.
module frame_ring_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_scheduler.sv
// Replays overlapping analysis frames out of a sample ring toward the window multiplier.
module frame_scheduler
  import frame_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CFG_W-1:0] cfg_frame_len,
  input  logic [CFG_W-1:0] cfg_hop_len,
  input  logic [DW-1:0]    sample_in,
  input  logic             sample_valid,
  output logic [DW-1:0]    out_sample,
  output logic [IDX_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic [FC_W-1:0]  frame_count,
  output logic             overrun,
  output logic             cfg_err,
  output logic             busy
);

  // Assert immediately, release two clocks after rst drops.
  logic [1:0] rst_sync_q;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_i = rst_sync_q[1];

  state_t           state_q, state_d;
  logic [AW-1:0]    wp_q, wp_d, fb_q, fb_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CFG_W-1:0] fl_q, fl_d, hl_q, hl_d, idx_q, idx_d;
  beat_t            beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic [FC_W-1:0]  frame_count_q, frame_count_d;
  logic             overrun_q, overrun_d;
  logic             cfg_err_q, cfg_err_d;
  logic             busy_q, busy_d;

  logic             wr_en_c, release_c, accept_c;
  logic [AW-1:0]    rd_addr_c;
  logic [DW-1:0]    rd_data_c;

  assign rd_addr_c = fb_q + AW'(idx_q);
  assign accept_c  = out_valid_q & out_ready;

  frame_ring_ram #(.DW(DW), .AW(AW)) u_ring (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wp_q),
    .wdata (sample_in),
    .raddr (rd_addr_c),
    .rdata (rd_data_c)
  );

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    fb_d          = fb_q;
    count_d       = count_q;
    fl_d          = fl_q;
    hl_d          = hl_q;
    idx_d         = idx_q;
    beat_d        = beat_q;
    out_valid_d   = out_valid_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    cfg_err_d     = cfg_err_q;
    wr_en_c       = 1'b0;
    release_c     = 1'b0;

    if (!enable) begin
      // Flush: abandon any frame in flight, keep only the frame counter.
      state_d     = ST_IDLE;
      wp_d        = '0;
      fb_d        = '0;
      count_d     = '0;
      idx_d       = '0;
      beat_d      = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
      cfg_err_d   = 1'b0;
    end else begin
      if (sample_valid && (state_q != ST_IDLE)) begin
        if (count_q < CNT_W'(DEPTH)) wr_en_c   = 1'b1;
        else                         overrun_d = 1'b1;
      end

      if (accept_c) out_valid_d = 1'b0;

      case (state_q)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          fl_d = cfg_frame_len;
          hl_d = cfg_hop_len;
          if (cfg_legal(cfg_frame_len, cfg_hop_len)) begin
            cfg_err_d = 1'b0;
            state_d   = ST_WAIT;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (count_q >= CNT_W'(fl_q)) begin
            idx_d   = '0;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if ((idx_q < fl_q) && (!out_valid_q || out_ready)) begin
            beat_d.sample = rd_data_c;
            beat_d.index  = idx_q[IDX_W-1:0];
            beat_d.first  = (idx_q == '0);
            beat_d.last   = (idx_q == (fl_q - CFG_W'(1)));
            out_valid_d   = 1'b1;
            idx_d         = idx_q + CFG_W'(1);
          end
          // Frame released once its last beat is taken.
          if (accept_c && beat_q.last) begin
            release_c     = 1'b1;
            fb_d          = fb_q + AW'(hl_q);
            frame_count_d = frame_count_q + FC_W'(1);
            state_d       = ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (wr_en_c) wp_d = wp_q + AW'(1);
      count_d = count_q + CNT_W'(wr_en_c) - (release_c ? CNT_W'(hl_q) : CNT_W'(0));
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wp_q          <= '0;
      fb_q          <= '0;
      count_q       <= '0;
      fl_q          <= '0;
      hl_q          <= '0;
      idx_q         <= '0;
      beat_q        <= '0;
      out_valid_q   <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      fb_q          <= fb_d;
      count_q       <= count_d;
      fl_q          <= fl_d;
      hl_q          <= hl_d;
      idx_q         <= idx_d;
      beat_q        <= beat_d;
      out_valid_q   <= out_valid_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      cfg_err_q     <= cfg_err_d;
      busy_q        <= busy_d;
    end
  end

  assign out_sample  = beat_q.sample;
  assign out_index   = beat_q.index;
  assign out_first   = beat_q.first;
  assign out_last    = beat_q.last;
  assign out_valid   = out_valid_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;
  assign cfg_err     = cfg_err_q;
  assign busy        = busy_q;

endmodule
